// File: rtl/nand_chain_seq_if.sv
// Operand/result handshake bundle for nand_chain_seq: the producer/consumer side
// uses the master modport, the controller uses the slave modport.
interface nand_chain_seq_if #(
  parameter int N_STAGES = 3,
  parameter int WIDTH    = 1
) ();
  logic                           in_valid;
  logic                           in_ready;
  logic [(N_STAGES+1)*WIDTH-1:0]  operands;
  logic                           abort;
  logic                           out_valid;
  logic                           out_ready;
  logic [WIDTH-1:0]               result;
  logic [3:0]                     stage;
  logic                           busy;

  modport master (
    output in_valid, operands, abort, out_ready,
    input  in_ready, out_valid, result, stage, busy
  );

  modport slave (
    input  in_valid, operands, abort, out_ready,
    output in_ready, out_valid, result, stage, busy
  );
endinterface

// File: rtl/nand_chain_seq.sv
// Multi-cycle NAND chain: one shared bitwise NAND evaluates one stage per clock.
// Define NAND_CHAIN_SEQ_TRACE_EN to add the per-stage trace output.
module nand_chain_seq #(
  parameter int N_STAGES = 3,
  parameter int WIDTH    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  nand_chain_seq_if.slave           bus
`ifdef NAND_CHAIN_SEQ_TRACE_EN
  ,
  output logic [N_STAGES*WIDTH-1:0] trace
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_STAGE = 4'(N_STAGES - 1);

  state_t                         state_reg, state_next;
  logic [(N_STAGES+1)*WIDTH-1:0]  op_reg;
  logic [WIDTH-1:0]               acc_reg;
  logic [WIDTH-1:0]               result_reg;
  logic [3:0]                     stage_reg;

  logic [WIDTH-1:0]               op_slice [16];
  logic [WIDTH-1:0]               nand_lhs, nand_rhs, nand_val;
  logic [3:0]                     rhs_idx;
  logic                           accept;
  logic                           last_stage;

  // Operand lanes padded to 16 entries so the stage-indexed mux never leaves the array.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slice
      if (gi <= N_STAGES) begin : g_used
        assign op_slice[gi] = op_reg[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign op_slice[gi] = '0;
      end
    end
  endgenerate

  assign accept     = (state_reg == IDLE) && bus.in_valid;
  assign last_stage = (stage_reg == LAST_STAGE);
  assign rhs_idx    = stage_reg + 4'd1;
  assign nand_lhs   = (stage_reg == 4'd0) ? op_slice[0] : acc_reg;
  assign nand_rhs   = op_slice[rhs_idx];
  assign nand_val   = ~(nand_lhs & nand_rhs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // abort outranks both stage advance and the output handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.in_valid) state_next = RUN;
      RUN: begin
        if (bus.abort)       state_next = IDLE;
        else if (last_stage) state_next = DONE;
      end
      DONE: begin
        if (bus.abort)          state_next = IDLE;
        else if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg     <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      stage_reg  <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            op_reg    <= bus.operands;
            stage_reg <= 4'd0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            acc_reg   <= '0;
            stage_reg <= 4'd0;
          end else begin
            acc_reg <= nand_val;
            if (last_stage) begin
              result_reg <= nand_val;
              stage_reg  <= 4'd0;
            end else begin
              stage_reg <= stage_reg + 4'd1;
            end
          end
        end
        DONE: begin
          if (bus.abort) acc_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.result    = result_reg;
  assign bus.stage     = (state_reg == RUN) ? stage_reg : 4'd0;

`ifdef NAND_CHAIN_SEQ_TRACE_EN
  logic [N_STAGES*WIDTH-1:0] trace_reg;

  // Each slice is captured on the edge that computes its stage; abort freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_reg <= '0;
    end else if (accept) begin
      trace_reg <= '0;
    end else if (state_reg == RUN && !bus.abort) begin
      for (int k = 0; k < N_STAGES; k++) begin
        if (stage_reg == 4'(k)) trace_reg[k*WIDTH +: WIDTH] <= nand_val;
      end
    end
  end

  assign trace = trace_reg;
`endif

endmodule

// File: doc/nand_chain_seq.md
Name: nand_chain_seq

Overview:
- Sequential controller that evaluates a parameterised NAND chain one stage per clock.
- Stage 0 computes ~(op0 & op1). Each following stage k computes ~(prev & op(k+1)).
- One shared bitwise NAND datapath is reused across all stages, driven by an FSM with valid/ready handshakes on input and output.
- Sits between an operand producer and a result consumer as the multi-cycle form of the team's cascaded-NAND gate blocks.

Parameters:
- N_STAGES, 3, number of NAND stages; legal range 1..15; operand count is N_STAGES+1.
- WIDTH, 1, bits per operand; each NAND is bitwise across all WIDTH lanes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept an operand set.
- operands  input  (N_STAGES+1)*WIDTH  op0 in bits [WIDTH-1:0], opK in bits [K*WIDTH +: WIDTH].
- abort  input  1  synchronous cancel of the operation in flight.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  final stage value.
- stage  output  4  index of the stage computed this cycle; 0 when not running.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values (asynchronous, rst=1):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - result=0, stage=0, operand register=0, accumulator=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: latch operands, stage counter:=0, go to RUN.
  - operands is sampled only at this edge; later changes are ignored.
- RUN:
  - in_ready=0.
  - At each edge: acc := ~(op0&op1) when stage==0, otherwise acc := ~(acc & op(stage+1)); then stage increments.
  - After the edge that computes stage N_STAGES-1: go to DONE and load result:=acc value.
  - RUN lasts exactly N_STAGES cycles.
- DONE:
  - out_valid=1. result is held stable until the handshake.
  - On out_valid&out_ready: go to IDLE; in_ready=1 the following cycle.
  - out_valid stays high indefinitely while out_ready=0.
- Latency:
  - Accept at edge T → out_valid high in the cycle after edge T+N_STAGES, i.e. N_STAGES+1 edges after acceptance.
  - Minimum spacing between accepts is N_STAGES+2 cycles when out_ready is held 1.
- abort:
  - Sampled in RUN or DONE → next state IDLE, out_valid=0, accumulator cleared.
  - Takes priority over stage advance and over the output handshake.
  - Ignored in IDLE; in_valid in the same cycle is still accepted.
- Simultaneous in_valid with a DONE handshake: not accepted that cycle, because in_ready=0 in DONE. No pipelining.
- rst asserted mid-operation: immediate return to reset values; the partial result is discarded.
- N_STAGES=1: single RUN cycle; result=~(op0&op1).
- stage output mirrors the internal counter in RUN. busy = state≠IDLE.

Optional Feature:
- Macro: NAND_CHAIN_SEQ_TRACE_EN.
- Defined:
  - Adds output port trace of width N_STAGES*WIDTH.
  - Slice k holds the value computed by stage k; each slice is written at the edge that computes it.
  - Cleared to 0 on reset and on acceptance of a new operand set.
  - Stable and complete while out_valid=1.
  - abort leaves trace contents unchanged.
- Undefined: no trace port and no trace storage; all other behaviour is identical.

Test Plan:
- Reset release, defaults (N_STAGES=3, WIDTH=1) → in_ready=1, out_valid=0, result=0, busy=0, stage=0.
- operands a,b,c,d=1,1,1,1, out_ready=1:
  - out_valid is first seen 4 edges after the accept edge, with result=0.
  - Trace (if enabled) = {g,f,e} = 3'b010.
  - in_ready=1 the cycle after the handshake.
- operands 0,1,1,1 → result=1, trace stages e=1,f=0,g=1. operands all 0 → result=1, trace 3'b111.
- Backpressure: out_ready=0 for 10 cycles after out_valid → result held constant, in_valid pulses ignored with in_ready=0. Then out_ready=1 → IDLE.
- abort during stage 1, then rst asserted mid-RUN on a second operation:
  - After abort: out_valid stays 0, next cycle in_ready=1.
  - On rst: all outputs return to reset values asynchronously, with no clock edge required.
- WIDTH=4, N_STAGES=1, op0=4'b1100, op1=4'b1010 → result=4'b0111 after 2 edges.
